ipu: RTL and testbench
======================

# ipu

Image processing unit: colour-target centroid tracker in the camera datapath. It consumes one RGB pixel per valid clock, together with its raster coordinates. It accumulates the X/Y coordinates of every pixel that passes a red-colour threshold over a frame. At frame end it divides the sums by the match count and emits the centroid (oX, oY) with a one-cycle valid strobe for downstream consumers (cursor/overlay logic).

## Interface
- FRAME_W, 640, active pixels per line
- FRAME_H, 480, active lines per frame
- RED_MIN, 12'h800, minimum iRed for a match
- GB_MAX, 12'h400, maximum iGreen and iBlue for a match
- MIN_COUNT, 16, minimum matches for a valid result (only with IPU_MIN_COUNT_EN)
- iCLK  in  1  single clock; all logic on its rising edge
- iRST  in  1  asynchronous, active-low reset
- iDVAL  in  1  pixel valid
- iRed / iGreen / iBlue  in  12 each  pixel colour
- iX_Cont  in  11  pixel column
- iY_Cont  in  11  pixel row
- oX  out  11  centroid column
- oY  out  11  centroid row
- oDVAL  out  1  one-cycle strobe: oX/oY updated

## Operation
- Pixel sampled only when iDVAL=1. Pixels with iX_Cont ≥ FRAME_W or iY_Cont ≥ FRAME_H are ignored entirely.
- Match: iRed ≥ RED_MIN and iGreen ≤ GB_MAX and iBlue ≤ GB_MAX (all comparisons unsigned, inclusive).
- On each match: sum_x += iX_Cont, sum_y += iY_Cont, count += 1.
  - sum_x and sum_y are SUM_W=28 bits; count is CNT_W=19 bits.
  - No overflow is possible within window limits.
- Frame end: a sampled valid pixel with iX_Cont == FRAME_W-1 and iY_Cont == FRAME_H-1.
  - On that edge, the totals including that pixel are snapshotted into divider operands.
  - Accumulators are cleared, so the next frame accumulates immediately.
- Divide: two unsigned restoring dividers run in parallel, sum_x/count and sum_y/count.
  - Quotients are truncated (floor).
  - Low 11 bits are registered into oX/oY; the result is always < FRAME_W/FRAME_H.
- count == 0 at frame end: no divide, no oDVAL; oX/oY hold their previous values.
- A frame end arriving while the dividers are busy: that frame's result is dropped, but its accumulators are still cleared.
- oX/oY hold their value between strobes.

## Timing
- Reset (async assert, sync release): oX=0, oY=0, oDVAL=0, accumulators=0, dividers idle.
- Reset mid-frame or mid-divide discards all partial state; no oDVAL follows.
- Frame end sampled at edge E:
  - Dividers start at E+1 and iterate SUM_W cycles.
  - oX/oY/oDVAL are registered at edge E+SUM_W+2 (E+30 by default).
  - oDVAL is high for exactly one cycle.
- Minimum frame-end spacing for no dropped results: SUM_W+2 cycles.

## Configuration
- IPU_MIN_COUNT_EN defined: a frame with count < MIN_COUNT is treated as count == 0 (no strobe, outputs hold).
- IPU_MIN_COUNT_EN undefined: any count ≥ 1 produces a result; the MIN_COUNT parameter is unused.

## Structure
- Package ipu_pkg: COORD_W=11, COLOR_W=12, SUM_W=28, CNT_W=19, default FRAME_W/FRAME_H/RED_MIN/GB_MAX/MIN_COUNT.
- Sub-module ipu_div: parameterised unsigned restoring divider (dividend SUM_W, divisor CNT_W).
  - Handshake: start in, one-cycle done out, quotient out.
  - Instantiated twice (X and Y).
- Top-level ipu contains the match logic, accumulators, frame-end detect, snapshot and output registers.

## Test plan
- Full 640×480 frame, all pixels red (12'hFFF,0,0), X 0..639, Y 0..479 -> single oDVAL 30 cycles after last pixel with oX=319, oY=239.
- Single red pixel at (100,50), all others black -> oX=100, oY=50.
- Red 10×10 square X 200..209, Y 300..309 -> oX=204, oY=304.
- All-black frame -> no oDVAL; oX/oY keep prior values (0 after reset).
- Threshold boundary:
  - Lone pixel iRed=12'h800, iGreen=iBlue=12'h400 matches.
  - Same pixel with iRed=12'h7FF, or iGreen=12'h401, gives no strobe.
  - With IPU_MIN_COUNT_EN: 15 matches give no strobe; 16 matches give a strobe.
- iRST pulsed low mid-frame after 1000 red pixels -> outputs 0 immediately; no stale strobe; the next full red frame gives oX=319, oY=239.

Source files
------------

// File: rtl/ipu_pkg.sv
// rtl/ipu_pkg.sv - shared widths, default thresholds and divider state type for the centroid tracker
package ipu_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 12;
  localparam int SUM_W   = 28;
  localparam int CNT_W   = 19;

  localparam int                 FRAME_W_DEF   = 640;
  localparam int                 FRAME_H_DEF   = 480;
  localparam logic [COLOR_W-1:0] RED_MIN_DEF   = 12'h800;
  localparam logic [COLOR_W-1:0] GB_MAX_DEF    = 12'h400;
  localparam int                 MIN_COUNT_DEF = 16;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_t;

endpackage

// File: rtl/ipu_if.sv
// rtl/ipu_if.sv - pixel input and centroid output bundle of the centroid tracker
interface ipu_if;
  import ipu_pkg::*;

  logic               iDVAL;
  logic [COLOR_W-1:0] iRed;
  logic [COLOR_W-1:0] iGreen;
  logic [COLOR_W-1:0] iBlue;
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic               oDVAL;

  modport slave (
    input  iDVAL, iRed, iGreen, iBlue, iX_Cont, iY_Cont,
    output oX, oY, oDVAL
  );

  modport master (
    output iDVAL, iRed, iGreen, iBlue, iX_Cont, iY_Cont,
    input  oX, oY, oDVAL
  );

endinterface

// File: rtl/ipu_div.sv
// rtl/ipu_div.sv - unsigned restoring divider, one quotient bit per cycle, only low Q_W quotient bits exported
module ipu_div
  import ipu_pkg::*;
#(
  parameter int DVD_W = SUM_W,
  parameter int DVS_W = CNT_W,
  parameter int Q_W   = COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int IW = $clog2(DVD_W + 1);

  div_state_t       state, state_nxt;
  logic [DVD_W-1:0] quot;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [IW-1:0]    iter;
  logic [DVS_W:0]   shifted;
  logic [DVS_W-1:0] diff;
  logic             fits;
  logic             last;

  assign shifted = {rem, quot[DVD_W-1]};
  assign fits    = shifted >= {1'b0, dvs};
  // Low bits suffice: when the divisor fits, the true difference is below dvs.
  assign diff    = shifted[DVS_W-1:0] - dvs;
  assign last    = (iter == IW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = DIV_RUN;
      DIV_RUN:  if (last)  state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot <= '0;
      rem  <= '0;
      dvs  <= '0;
      iter <= '0;
      done <= 1'b0;
    end else begin
      done <= busy && last;
      if (!busy && start) begin
        quot <= dividend;
        rem  <= '0;
        dvs  <= divisor;
        iter <= IW'(DVD_W);
      end else if (busy) begin
        quot <= {quot[DVD_W-2:0], fits};
        rem  <= fits ? diff : shifted[DVS_W-1:0];
        iter <= iter - IW'(1);
      end
    end
  end

  assign quotient = quot[Q_W-1:0];

endmodule

// File: rtl/ipu.sv
// rtl/ipu.sv - red-target centroid tracker: match, accumulate per frame, divide, strobe (oX, oY)
// Optional IPU_MIN_COUNT_EN: frames with fewer than MIN_COUNT matches produce no result.
module ipu
  import ipu_pkg::*;
#(
  parameter int                 FRAME_W = FRAME_W_DEF,
  parameter int                 FRAME_H = FRAME_H_DEF,
  parameter logic [COLOR_W-1:0] RED_MIN = RED_MIN_DEF,
  parameter logic [COLOR_W-1:0] GB_MAX  = GB_MAX_DEF
) (
  input  logic iCLK,
  input  logic iRST,
  ipu_if.slave bus
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - 1);

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [SUM_W-1:0]   sum_x, sum_y, sum_x_nxt, sum_y_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [SUM_W-1:0]   op_x, op_y;
  logic [CNT_W-1:0]   op_cnt;
  logic               start_q;
  logic               busy_x, busy_y, done_x, done_y;
  logic [COORD_W-1:0] q_x, q_y;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic               odval_q;
  logic               in_window, hit, frame_end, count_ok, div_idle;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_window = (bus.iX_Cont <= X_LAST) && (bus.iY_Cont <= Y_LAST);
  assign hit       = bus.iDVAL && in_window && (bus.iRed >= RED_MIN)
                   && (bus.iGreen <= GB_MAX) && (bus.iBlue <= GB_MAX);
  assign frame_end = bus.iDVAL && (bus.iX_Cont == X_LAST) && (bus.iY_Cont == Y_LAST);

  assign sum_x_nxt = sum_x + (hit ? SUM_W'(bus.iX_Cont) : '0);
  assign sum_y_nxt = sum_y + (hit ? SUM_W'(bus.iY_Cont) : '0);
  assign count_nxt = count + (hit ? CNT_W'(1) : '0);

`ifdef IPU_MIN_COUNT_EN
  assign count_ok = (count_nxt >= CNT_W'(MIN_COUNT_DEF));
`else
  assign count_ok = (count_nxt != '0);
`endif

  // start_q covers the cycle before the dividers report busy.
  assign div_idle = !start_q && !busy_x && !busy_y;

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      sum_x   <= '0;
      sum_y   <= '0;
      count   <= '0;
      op_x    <= '0;
      op_y    <= '0;
      op_cnt  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
        if (count_ok && div_idle) begin
          op_x    <= sum_x_nxt;
          op_y    <= sum_y_nxt;
          op_cnt  <= count_nxt;
          start_q <= 1'b1;
        end
      end else begin
        sum_x <= sum_x_nxt;
        sum_y <= sum_y_nxt;
        count <= count_nxt;
      end
    end
  end

  ipu_div #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_x (
    .clk      (iCLK),
    .rst_n    (rst_n),
    .start    (start_q),
    .dividend (op_x),
    .divisor  (op_cnt),
    .busy     (busy_x),
    .done     (done_x),
    .quotient (q_x)
  );

  ipu_div #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_y (
    .clk      (iCLK),
    .rst_n    (rst_n),
    .start    (start_q),
    .dividend (op_y),
    .divisor  (op_cnt),
    .busy     (busy_y),
    .done     (done_y),
    .quotient (q_y)
  );

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      ox_q    <= '0;
      oy_q    <= '0;
      odval_q <= 1'b0;
    end else begin
      odval_q <= done_x && done_y;
      if (done_x && done_y) begin
        ox_q <= q_x;
        oy_q <= q_y;
      end
    end
  end

  assign bus.oX    = ox_q;
  assign bus.oY    = oy_q;
  assign bus.oDVAL = odval_q;

endmodule

// File: tb/tb_ipu.sv
// tb/tb_ipu.sv - directed-vector bench for ipu on a reduced 256x64 window
module tb_ipu;

  localparam int TW = 256;
  localparam int TH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ipu_if bus ();

  ipu #(.FRAME_W(TW), .FRAME_H(TH)) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] r, input logic [11:0] g,
                     input logic [11:0] b);
    @(negedge clk);
    bus.iDVAL   = 1'b1;
    bus.iX_Cont = 11'(x);
    bus.iY_Cont = 11'(y);
    bus.iRed    = r;
    bus.iGreen  = g;
    bus.iBlue   = b;
    @(posedge clk);
  endtask

  task automatic red(input int x, input int y);
    pix(x, y, 12'hFFF, 12'h000, 12'h000);
  endtask

  task automatic end_frame();
    pix(TW - 1, TH - 1, 12'h000, 12'h000, 12'h000);
  endtask

  task automatic full_red();
    for (int y = 0; y < TH; y++)
      for (int x = 0; x < TW; x++)
        red(x, y);
  endtask

  // Called right after the frame-end edge; exp_lat < 0 means no strobe expected.
  task automatic wait_result(input string tag, input int exp_lat, input int ex, input int ey);
    int lat;
    int n;
    lat = -1;
    n = 0;
    @(negedge clk);
    bus.iDVAL = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.oDVAL) begin
        n++;
        if (lat < 0) lat = k;
      end
    end
    if (exp_lat >= 0) begin
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_nstrobe"}, 32'(n), 32'd1);
    end else begin
      check_eq({tag, "_nstrobe"}, 32'(n), 32'd0);
    end
    check_eq({tag, "_x"}, 32'(bus.oX), 32'(ex));
    check_eq({tag, "_y"}, 32'(bus.oY), 32'(ey));
  endtask

  initial begin
    bus.iDVAL   = 1'b0;
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    bus.iRed    = '0;
    bus.iGreen  = '0;
    bus.iBlue   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_x", 32'(bus.oX), 32'd0);
    check_eq("rst_y", 32'(bus.oY), 32'd0);
    check_eq("rst_dval", 32'(bus.oDVAL), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    end_frame();
    wait_result("black0", -1, 0, 0);

    full_red();
    wait_result("full", 30, 127, 31);

    red(100, 50);
    end_frame();
    wait_result("single", 30, 100, 50);

    for (int y = 40; y < 50; y++)
      for (int x = 200; x < 210; x++)
        red(x, y);
    end_frame();
    wait_result("square", 30, 204, 44);

    end_frame();
    wait_result("black_hold", -1, 204, 44);

    pix(5, 6, 12'h800, 12'h400, 12'h400);
    end_frame();
    wait_result("thr_edge", 30, 5, 6);
    pix(9, 9, 12'h7FF, 12'h400, 12'h400);
    end_frame();
    wait_result("thr_red", -1, 5, 6);
    pix(9, 9, 12'h800, 12'h401, 12'h400);
    end_frame();
    wait_result("thr_green", -1, 5, 6);
    pix(9, 9, 12'h800, 12'h400, 12'h401);
    end_frame();
    wait_result("thr_blue", -1, 5, 6);

    red(300, 10);
    red(10, 70);
    red(8, 4);
    end_frame();
    wait_result("window", 30, 8, 4);

    for (int i = 0; i < 15; i++) red(i, 2);
    end_frame();
`ifdef IPU_MIN_COUNT_EN
    wait_result("min15", -1, 8, 4);
`else
    wait_result("min15", 30, 7, 2);
`endif
    for (int i = 0; i < 16; i++) red(i, 3);
    end_frame();
    wait_result("min16", 30, 7, 3);

    red(40, 20);
    end_frame();
    red(60, 30);
    end_frame();
    wait_result("busy_drop", 28, 40, 20);
    red(70, 10);
    end_frame();
    wait_result("after_drop", 30, 70, 10);

    for (int i = 0; i < 1000; i++) red(i % TW, i / TW);
    @(negedge clk);
    rst_n = 1'b0;
    bus.iDVAL = 1'b0;
    #1;
    check_eq("midrst_x", 32'(bus.oX), 32'd0);
    check_eq("midrst_y", 32'(bus.oY), 32'd0);
    check_eq("midrst_dval", 32'(bus.oDVAL), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    end_frame();
    wait_result("post_rst", -1, 0, 0);
    full_red();
    wait_result("post_rst_full", 30, 127, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
